// File: rtl/shifter_pkg.sv
// Shared types and helpers for the iterative shifter and its single-step datapath.
package shifter_pkg;

  typedef enum logic [1:0] {
    SH_LOGIC = 2'b00,
    SH_ARITH = 2'b01,
    SH_ROT   = 2'b10,
    SH_RSVD  = 2'b11
  } sh_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } sh_state_t;

  localparam logic SH_RIGHT = 1'b0;
  localparam logic SH_LEFT  = 1'b1;

  // Largest per-cycle shift ever requested: amounts never exceed WIDTH-1.
  function automatic int max_step(input int width, input int step);
    return (step < width) ? step : width - 1;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter (0..STEP bits) with fill and per-step overflow.
// Rotation is built only when ITERATIVE_SHIFTER_ROTATE_EN is defined.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  localparam int MAX_S = max_step(WIDTH, STEP),
  localparam int SW    = $clog2(MAX_S + 1)
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_dir,
  input  sh_mode_t         i_mode,
  input  logic             i_sign,
  input  logic [SW-1:0]    i_amt,
  output logic [WIDTH-1:0] o_data,
  output logic             o_ovf
);

  logic             w_arith;
  logic [WIDTH-1:0] w_res [MAX_S+1];
  logic             w_ovf [MAX_S+1];

  assign w_arith  = (i_mode == SH_ARITH);
  assign w_res[0] = i_data;
  assign w_ovf[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi <= MAX_S; gi++) begin : g_amt
      logic [gi-1:0] w_rfill;
      logic [gi-1:0] w_lfill;
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
      logic w_rot;
      assign w_rot   = (i_mode == SH_ROT);
      assign w_rfill = w_rot ? i_data[gi-1:0] : (w_arith ? {gi{i_sign}} : '0);
      assign w_lfill = w_rot ? i_data[WIDTH-1 -: gi] : '0;
`else
      assign w_rfill = w_arith ? {gi{i_sign}} : '0;
      assign w_lfill = '0;
`endif
      assign w_res[gi] = (i_dir == SH_LEFT) ? {i_data[WIDTH-1-gi:0], w_lfill}
                                            : {w_rfill, i_data[WIDTH-1:gi]};
      // Bits that will pass through the MSB during this step must all match the original sign.
      assign w_ovf[gi] = (i_dir == SH_LEFT) && w_arith &&
                         (|(i_data[WIDTH-2 -: gi] ^ {gi{i_sign}}));
    end
  endgenerate

  always_comb begin
    o_data = w_res[0];
    o_ovf  = w_ovf[0];
    for (int k = 1; k <= MAX_S; k++) begin
      if (i_amt == SW'(k)) begin
        o_data = w_res[k];
        o_ovf  = w_ovf[k];
      end
    end
  end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle shifter: STEP bits per clock, Done pulse, sticky arithmetic-left overflow.
// Optional rotate mode is enabled by defining ITERATIVE_SHIFTER_ROTATE_EN.
module iterative_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic             Sh_dir,
  input  logic [1:0]       Sh_mode,
  input  logic [AMT_W-1:0] Sh_amt,
  input  logic [WIDTH-1:0] D_in,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] D_out,
  output logic             Ovf
);

  localparam int MAX_S = max_step(WIDTH, STEP);
  localparam int SW    = $clog2(MAX_S + 1);

  sh_state_t        r_state;
  sh_mode_t         r_mode;
  logic [WIDTH-1:0] r_work;
  logic [AMT_W-1:0] r_rem;
  logic             r_dir;
  logic             r_sign;
  logic             r_ovf_acc;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_dout;
  logic             r_ovf;

  logic [SW-1:0]    w_s;
  logic             w_last;
  logic [WIDTH-1:0] w_step_data;
  logic             w_step_ovf;

  always_comb begin
    w_s    = (int'(r_rem) > MAX_S) ? SW'(MAX_S) : SW'(r_rem);
    w_last = (r_rem == AMT_W'(w_s));
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .i_data (r_work),
    .i_dir  (r_dir),
    .i_mode (r_mode),
    .i_sign (r_sign),
    .i_amt  (w_s),
    .o_data (w_step_data),
    .o_ovf  (w_step_ovf)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state   <= ST_IDLE;
      r_mode    <= SH_LOGIC;
      r_work    <= '0;
      r_rem     <= '0;
      r_dir     <= SH_RIGHT;
      r_sign    <= 1'b0;
      r_ovf_acc <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dout    <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_SHIFT: begin
          r_work    <= w_step_data;
          r_rem     <= r_rem - AMT_W'(w_s);
          r_ovf_acc <= r_ovf_acc | w_step_ovf;
          if (w_last) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          // Results are committed on the edge that leaves DONE, so a new request can overlap it.
          if (r_state == ST_DONE) begin
            r_done <= 1'b1;
            r_dout <= r_work;
            r_ovf  <= r_ovf_acc;
          end
          if (Start) begin
            r_work    <= D_in;
            r_dir     <= Sh_dir;
            r_mode    <= sh_mode_t'(Sh_mode);
            r_rem     <= Sh_amt;
            r_sign    <= D_in[WIDTH-1];
            r_ovf_acc <= 1'b0;
            if (Sh_amt == '0) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_SHIFT;
              r_busy  <= 1'b1;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign Busy  = r_busy;
  assign Done  = r_done;
  assign D_out = r_dout;
  assign Ovf   = r_ovf;

endmodule

// File: tb/tb_iterative_shifter.sv
// Scoreboard bench for iterative_shifter: one instance with STEP=1 and one with STEP=4.
// Rotate expectations follow ITERATIVE_SHIFTER_ROTATE_EN.
module tb_iterative_shifter;

`ifdef ITERATIVE_SHIFTER_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] d;
    logic        o;
    int          due;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start_s [2];
  logic        dir_s   [2];
  logic [1:0]  mode_s  [2];
  logic [4:0]  amt_s   [2];
  logic [31:0] din_s   [2];
  logic        busy_s  [2];
  logic        done_s  [2];
  logic [31:0] dout_s  [2];
  logic        ovf_s   [2];

  int   cyc;
  int   n_cmp;
  int   n_bad;
  exp_t q0[$];
  exp_t q1[$];

  iterative_shifter #(.WIDTH(32), .STEP(1)) u_dut_s1 (
    .Clk(clk), .Rst(rst), .Start(start_s[0]), .Sh_dir(dir_s[0]), .Sh_mode(mode_s[0]),
    .Sh_amt(amt_s[0]), .D_in(din_s[0]), .Busy(busy_s[0]), .Done(done_s[0]),
    .D_out(dout_s[0]), .Ovf(ovf_s[0])
  );

  iterative_shifter #(.WIDTH(32), .STEP(4)) u_dut_s4 (
    .Clk(clk), .Rst(rst), .Start(start_s[1]), .Sh_dir(dir_s[1]), .Sh_mode(mode_s[1]),
    .Sh_amt(amt_s[1]), .D_in(din_s[1]), .Busy(busy_s[1]), .Done(done_s[1]),
    .D_out(dout_s[1]), .Ovf(ovf_s[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic int step_of(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  // Reference: whole-amount shift in one go; overflow when shifting back loses the operand.
  function automatic logic [32:0] model(input logic [31:0] d, input logic dir,
                                        input logic [1:0] mode, input int amt);
    logic [31:0] r;
    logic        o;
    logic        rot;
    o   = 1'b0;
    rot = (mode == 2'b10) && ROT_EN;
    if (!dir) begin
      if (rot)                r = (d >> amt) | (d << (32 - amt));
      else if (mode == 2'b01) r = $unsigned($signed(d) >>> amt);
      else                    r = d >> amt;
    end else begin
      if (rot) r = (d << amt) | (d >> (32 - amt));
      else     r = d << amt;
      if (mode == 2'b01) o = (($signed(r) >>> amt) != $signed(d));
    end
    return {o, r};
  endfunction

  task automatic mon(input int k);
    exp_t e;
    if (qsize(k) == 0) begin
      chk_eq($sformatf("s%0d_spurious_done", step_of(k)), 32'd1, 32'd0);
    end else begin
      if (k == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      chk_eq($sformatf("s%0d_dout", step_of(k)), dout_s[k], e.d);
      chk_eq($sformatf("s%0d_ovf", step_of(k)), {31'd0, ovf_s[k]}, {31'd0, e.o});
      chk_eq($sformatf("s%0d_done_edge", step_of(k)), cyc, e.due);
      $display("s%0d op done: dout=%h ovf=%0d edge=%0d", step_of(k), dout_s[k], ovf_s[k], cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (done_s[0]) mon(0);
      if (done_s[1]) mon(1);
    end
  end

  // Called at a negedge; Start is sampled at the following posedge, whose number is returned.
  task automatic drive(input int k, input logic [31:0] d, input logic dir,
                       input logic [1:0] mode, input int amt, output int e0);
    exp_t e;
    int   s;
    s          = step_of(k);
    din_s[k]   = d;
    dir_s[k]   = dir;
    mode_s[k]  = mode;
    amt_s[k]   = amt[4:0];
    start_s[k] = 1'b1;
    @(negedge clk);
    e0         = cyc;
    start_s[k] = 1'b0;
    {e.o, e.d} = model(d, dir, mode, amt);
    e.due      = e0 + 1 + (amt + s - 1) / s;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic wait_q(input int k, output int busy_cnt);
    busy_cnt = 0;
    for (int i = 0; i < 200 && qsize(k) != 0; i++) begin
      if (busy_s[k]) busy_cnt++;
      @(negedge clk);
    end
    chk_eq($sformatf("s%0d_drain", step_of(k)), qsize(k), 0);
    if (k == 0) q0.delete();
    else        q1.delete();
  endtask

  task automatic run(input int k, input logic [31:0] d, input logic dir,
                     input logic [1:0] mode, input int amt);
    int e0;
    int bc;
    drive(k, d, dir, mode, amt, e0);
    wait_q(k, bc);
    chk_eq($sformatf("s%0d_busy_cycles", step_of(k)), bc, (amt + step_of(k) - 1) / step_of(k));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0;
    int bc;
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start_s[k] = 1'b0; dir_s[k] = 1'b0; mode_s[k] = 2'b00; amt_s[k] = '0; din_s[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk_eq("reset_busy", {31'd0, busy_s[k]}, 32'd0);
      chk_eq("reset_done", {31'd0, done_s[k]}, 32'd0);
      chk_eq("reset_dout", dout_s[k], 32'd0);
      chk_eq("reset_ovf",  {31'd0, ovf_s[k]}, 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Directed cases on STEP=1.
    run(0, 32'h8000_00F0, 1'b0, 2'b01, 4);
    run(0, 32'h4000_0001, 1'b1, 2'b01, 1);
    run(0, 32'hC000_0001, 1'b1, 2'b01, 1);
    run(0, 32'hFFFF_FFFF, 1'b1, 2'b01, 31);
    run(0, 32'h0000_0001, 1'b0, 2'b10, 1);
    run(0, 32'hA5A5_0F0F, 1'b0, 2'b11, 8);

    // Zero amount followed by a request accepted in its DONE cycle.
    drive(0, 32'h1234_5678, 1'b0, 2'b00, 0, e0);
    drive(0, 32'h8000_0000, 1'b0, 2'b00, 31, e0);
    wait_q(0, bc);

    // Start issued on the edge the previous op sits in DONE.
    drive(0, 32'h0000_00F0, 1'b1, 2'b00, 3, e0);
    repeat (3) @(negedge clk);
    drive(0, 32'hF000_0000, 1'b0, 2'b01, 2, e0);
    wait_q(0, bc);

    // Start pulsed mid-shift must be ignored.
    drive(0, 32'h0000_0003, 1'b1, 2'b00, 10, e0);
    repeat (3) @(negedge clk);
    din_s[0] = 32'hFFFF_FFFF; dir_s[0] = 1'b0; mode_s[0] = 2'b01; amt_s[0] = 5'd2;
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    wait_q(0, bc);
    repeat (5) @(negedge clk);

    // Reset mid-shift discards the op and clears outputs immediately.
    drive(0, 32'h0F0F_0F0F, 1'b1, 2'b00, 20, e0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    q0.delete();
    #1;
    chk_eq("midrst_busy", {31'd0, busy_s[0]}, 32'd0);
    chk_eq("midrst_done", {31'd0, done_s[0]}, 32'd0);
    chk_eq("midrst_dout", dout_s[0], 32'd0);
    chk_eq("midrst_ovf",  {31'd0, ovf_s[0]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    run(0, 32'h0000_FFFF, 1'b1, 2'b00, 16);

    // Directed cases on STEP=4.
    run(1, 32'h0000_00FF, 1'b1, 2'b00, 9);
    run(1, 32'h0F00_0000, 1'b1, 2'b01, 4);
    run(1, 32'hF800_0000, 1'b1, 2'b01, 4);
    run(1, 32'h8000_0001, 1'b1, 2'b10, 5);
    run(1, 32'h8765_4321, 1'b0, 2'b01, 31);
    drive(1, 32'h0000_0101, 1'b1, 2'b01, 7, e0);
    repeat (2) @(negedge clk);
    drive(1, 32'h1234_5678, 1'b0, 2'b00, 0, e0);
    wait_q(1, bc);

    // Random operations alternating between instances.
    for (int i = 0; i < 12; i++) begin
      run(i % 2, $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          int'($urandom_range(0, 31)));
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/iterative_shifter.md
# iterative_shifter

Multi-cycle, parametrised shifter that replaces the single-shot combinational arithmetic shifter in the ch4 datapath. It accepts an operand, direction, mode and amount on a `Start` strobe, then shifts `STEP` bits per clock. It reports completion with a one-cycle `Done` pulse and holds the result on `D_out`. It also raises a sticky overflow flag for arithmetic left shifts and optionally supports rotation.

## Interface
- `WIDTH`, 32: data width; must be a power of two and ≥ 4.
- `STEP`, 1: bits shifted per cycle; must be a power of two and ≤ `WIDTH`.
- `AMT_W`, `$clog2(WIDTH)`: width of the shift amount.

- `Clk`  in  1: clock; all state updates on the rising edge.
- `Rst`  in  1: reset, asynchronous, active-high.
- `Start`  in  1: request strobe; sampled only in IDLE or DONE.
- `Sh_dir`  in  1: 0 = right, 1 = left.
- `Sh_mode`  in  2: 00 = logical, 01 = arithmetic, 10 = rotate, 11 = reserved.
- `Sh_amt`  in  `AMT_W`: shift amount, 0 to `WIDTH-1`.
- `D_in`  in  `WIDTH`: operand, treated as signed in arithmetic mode.
- `Busy`  out  1: high while in SHIFT.
- `Done`  out  1: one-cycle completion pulse.
- `D_out`  out  `WIDTH`: result, held until the next completion.
- `Ovf`  out  1: arithmetic-left overflow for the last operation.

## Operation
- FSM states are IDLE, SHIFT and DONE; the reset state is IDLE.
- IDLE + `Start`:
  - latch `D_in`, `Sh_dir`, `Sh_mode` and `Sh_amt` into working registers; clear the overflow accumulator.
  - go to DONE if `Sh_amt == 0`, otherwise go to SHIFT.
- SHIFT, each cycle:
  - s = min(`STEP`, rem); shift the working register by s; rem -= s.
  - when rem reaches 0 this cycle, load `D_out` and `Ovf` and go to DONE.
- DONE:
  - `Done` = 1 for exactly this cycle.
  - `Start` here is accepted exactly as in IDLE, allowing back-to-back operations; otherwise go to IDLE.
- `Start` during SHIFT is ignored: no queueing and no restart. Operands are sampled only on acceptance.
- Fill rules:
  - logical right: fill with 0.
  - arithmetic right: fill with the latched sign bit, `D_in[WIDTH-1]`.
  - left, logical or arithmetic: fill with 0. The sign bit is not preserved.
- `Ovf` (arithmetic left only): set if any bit that passes through position `WIDTH-1` differs from the original sign bit. Equivalently, overflow occurs when the result ≠ operand × 2^amt in signed `WIDTH`-bit arithmetic. `Ovf` is 0 in all other modes.
- Mode 11 behaves exactly as logical.
- All arithmetic is done at `WIDTH` bits; the rem counter is `AMT_W` bits wide.

## Timing
- Reset values: state = IDLE, `Busy` = 0, `Done` = 0, `D_out` = 0, `Ovf` = 0, working registers = 0.
- `Start` sampled at edge 0 with amount N:
  - `Busy` is high from edge 0 through the last SHIFT cycle.
  - `Done`, `D_out` and `Ovf` update at edge 1 + ceil(N/`STEP`).
  - N = 0 gives `Done` at edge 1 with `D_out` = `D_in`.
- Worst-case latency is 1 + ceil((`WIDTH`-1)/`STEP`) cycles.
- Back-to-back: `Start` during the `Done` cycle begins the next operation with no idle gap.
- `D_out` and `Ovf` change only at completion; they are stable between `Done` pulses.
- `Rst` asserted mid-operation: immediate return to IDLE with all outputs at reset values. The in-flight operation is discarded and no `Done` is produced.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `ITERATIVE_SHIFTER_ROTATE_EN` defined: mode 10 rotates, with bits leaving one end entering the other, in either direction. `Ovf` = 0.
- Not defined: mode 10 is treated as logical, and no rotate mux is built.

## Structure
- Shared package `shifter_pkg`:
  - `sh_mode_t` enum: `SH_LOGIC`, `SH_ARITH`, `SH_ROT`, `SH_RSVD`.
  - `sh_state_t` enum: `ST_IDLE`, `ST_SHIFT`, `ST_DONE`.
  - constants `SH_RIGHT` = 0 and `SH_LEFT` = 1.
- One sub-module, `shift_step`: combinational single-step shifter that shifts by s ≤ `STEP`, applying direction, mode and fill. It also outputs the per-step overflow bit. The top level holds the FSM, counter and registers.

## Test plan
- `WIDTH`=32, `STEP`=1, arithmetic right, `D_in`=0x8000_00F0, amt=4 -> `D_out`=0xF800_000F; `Done` at edge 5; `Busy` high for 4 cycles.
- `STEP`=4, logical left, `D_in`=0x0000_00FF, amt=9 -> `D_out`=0x0001_FE00; `Done` at edge 4; `Ovf`=0.
- Arithmetic left, `D_in`=0x4000_0001, amt=1 -> `D_out`=0x8000_0002, `Ovf`=1. Then `D_in`=0xC000_0001, amt=1 -> `Ovf`=0.
- amt=0, `D_in`=0x1234_5678 -> `Done` at edge 1, `D_out`=0x1234_5678. Then `Start` in the `Done` cycle with amt=31 logical right, `D_in`=0x8000_0000 -> `D_out`=0x0000_0001, with no idle cycle between operations.
- `Start` pulsed during SHIFT is ignored (result matches the first request). `Rst` mid-SHIFT -> outputs zero, no `Done`, and the next `Start` works normally.
- With `ITERATIVE_SHIFTER_ROTATE_EN`, rotate right, `D_in`=0x0000_0001, amt=1 -> 0x8000_0000. Without it -> 0x0000_0000.
